// File: rtl/cav4_lb_sequencer_if.sv
// Local-bus write port of one cav4_mode instance: the host write channel in,
// the single shared lb write strobe out.
interface cav4_lb_sequencer_if #(
  parameter int AW = 15,
  parameter int DW = 32
);
  // Host channel: a write transfers on every rising clk edge where host_write
  // and host_ready are both high; while host_ready is low the master holds
  // host_write, host_addr and host_data stable until the transfer completes.
  logic [DW-1:0] host_data;
  logic [AW-1:0] host_addr;
  logic          host_write;
  logic          host_ready;
  logic [DW-1:0] lb_data;
  logic [AW-1:0] lb_addr;
  logic          lb_write;

  modport master (
    output host_data, host_addr, host_write,
    input  host_ready, lb_data, lb_addr, lb_write
  );

  modport slave (
    input  host_data, host_addr, host_write,
    output host_ready, lb_data, lb_addr, lb_write
  );
endinterface

// File: rtl/cav4_lb_sequencer.sv
// Shares one cav4_mode local-bus write port between the host and an init
// sequencer that replays an {addr,data} table from an external 1-cycle ROM.
module cav4_lb_sequencer #(
  parameter int AW         = 15,
  parameter int DW         = 32,
  parameter int N_ENTRIES  = 4,
  parameter int GAP_CYCLES = 1,
  parameter int AUTO_START = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  cav4_lb_sequencer_if.slave        bus,
  output logic [$clog2(N_ENTRIES > 1 ? N_ENTRIES : 2)-1:0] tbl_addr,
  input  logic [AW+DW-1:0]          tbl_data,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                dbg_state
);

  localparam int TAW = $clog2(N_ENTRIES > 1 ? N_ENTRIES : 2);
  localparam int IW  = $clog2(N_ENTRIES + 1);
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            pend_q, pend_d;
  logic            live_q, live_d;
  logic [TAW-1:0]  tbl_addr_q, tbl_addr_d;
  logic [AW-1:0]   lb_addr_q, lb_addr_d;
  logic [DW-1:0]   lb_data_q, lb_data_d;
  logic            lb_write_q, lb_write_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            host_ready;
  logic            host_acc;
  logic            tbl_term;

  // live_q keeps host_ready low while rst_n is asserted even when no auto replay is pending.
  assign host_ready = (state_q == S_IDLE) && !pend_q && live_q;
  assign host_acc   = bus.host_write && host_ready;
  assign tbl_term   = &tbl_data[AW+DW-1:DW];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    pend_d     = pend_q;
    live_d     = 1'b1;
    tbl_addr_d = tbl_addr_q;
    lb_addr_d  = lb_addr_q;
    lb_data_d  = lb_data_q;
    lb_write_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (host_acc) begin
          // Host write goes out first; a same-cycle start waits one cycle in pend.
          lb_addr_d  = bus.host_addr;
          lb_data_d  = bus.host_data;
          lb_write_d = 1'b1;
          if (start) pend_d = 1'b1;
        end else if (start || pend_q) begin
          state_d = S_FETCH;
          idx_d   = '0;
          busy_d  = 1'b1;
          pend_d  = 1'b0;
        end
      end
      S_FETCH: begin
        tbl_addr_d = idx_q[TAW-1:0];
        state_d    = S_WAIT;
      end
      S_WAIT: state_d = S_WRITE;
      S_WRITE: begin
        if (tbl_term) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          lb_addr_d  = tbl_data[AW+DW-1:DW];
          lb_data_d  = tbl_data[DW-1:0];
          lb_write_d = 1'b1;
          idx_d      = idx_q + 1'b1;
          gap_d      = '0;
          if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
          end else if (int'(idx_d) == N_ENTRIES) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_GAP: begin
        if (int'(gap_q) + 1 >= GAP_CYCLES) begin
          if (int'(idx_q) == N_ENTRIES) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      gap_q      <= '0;
      pend_q     <= (AUTO_START != 0);
      live_q     <= 1'b0;
      tbl_addr_q <= '0;
      lb_addr_q  <= '0;
      lb_data_q  <= '0;
      lb_write_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      pend_q     <= pend_d;
      live_q     <= live_d;
      tbl_addr_q <= tbl_addr_d;
      lb_addr_q  <= lb_addr_d;
      lb_data_q  <= lb_data_d;
      lb_write_q <= lb_write_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.host_ready = host_ready;
  assign bus.lb_addr    = lb_addr_q;
  assign bus.lb_data    = lb_data_q;
  assign bus.lb_write   = lb_write_q;
  assign tbl_addr       = tbl_addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_cav4_lb_sequencer.sv
// Bench for cav4_lb_sequencer: a GAP_CYCLES=1 instance under directed and random
// traffic plus a GAP_CYCLES=0 instance doing auto replays, both against a cycle-timeline model.
module tb_cav4_lb_sequencer;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int G  = 1;
  localparam int TW = AW + DW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start  = 1'b0;
  logic          start0 = 1'b0;
  logic [1:0]    tbl_addr, s0_tbl_addr;
  logic [TW-1:0] tbl_data, s0_tbl_data;
  logic          busy, done, s0_busy, s0_done;
  logic [2:0]    dbg_state, s0_dbg;
  logic [TW-1:0] rom  [N];
  logic [TW-1:0] rom0 [N];

  cav4_lb_sequencer_if #(.AW(AW), .DW(DW)) hbus ();
  cav4_lb_sequencer_if #(.AW(AW), .DW(DW)) hbus0 ();

  cav4_lb_sequencer #(.AW(AW), .DW(DW), .N_ENTRIES(N), .GAP_CYCLES(G), .AUTO_START(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(hbus),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  cav4_lb_sequencer #(.AW(AW), .DW(DW), .N_ENTRIES(N), .GAP_CYCLES(0), .AUTO_START(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .bus(hbus0),
    .tbl_addr(s0_tbl_addr), .tbl_data(s0_tbl_data),
    .busy(s0_busy), .done(s0_done), .dbg_state(s0_dbg)
  );

  // External table ROMs with one cycle of read latency.
  always @(posedge clk) begin
    tbl_data    <= rom[tbl_addr];
    s0_tbl_data <= rom0[s0_tbl_addr];
  end

  // ---------------- reference model ----------------
  // Timeline: a replay launched in cycle c0 issues entry i in cycle c0+4+i*(3+gap);
  // done lands at c0+1+N*(3+gap), or at c0+4+k*(3+gap) when entry k is a terminator.
  int n_cmp = 0;
  int n_bad = 0;
  bit in_rst = 1'b1;

  logic [TW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            done_at = -1, busy_from = 1, busy_to = 0, blk_from = 1, blk_to = 0;

  logic [TW-1:0] exp0_q[$];
  int            exp0_cyc_q[$];
  int            m0_done_at = -1, m0_busy_from = 1, m0_busy_to = 0, m0_blk_from = 1, m0_blk_to = 0;

  function automatic bit model_ready(int c);
    return !in_rst && !(c >= blk_from && c <= blk_to);
  endfunction

  function automatic bit model0_ready(int c);
    return !in_rst && !(c >= m0_blk_from && c <= m0_blk_to);
  endfunction

  function automatic void schedule(int c0);
    int p;
    p = 3 + G;
    done_at = c0 + 1 + N * p;
    for (int i = 0; i < N; i++) begin
      if (rom[i][TW-1:DW] == {AW{1'b1}}) begin
        done_at = c0 + 4 + i * p;
        break;
      end
      exp_q.push_back(rom[i]);
      exp_cyc_q.push_back(c0 + 4 + i * p);
    end
    busy_from = c0 + 1;
    busy_to   = done_at;
    blk_to    = done_at;
  endfunction

  function automatic void schedule0(int c0);
    for (int i = 0; i < N; i++) begin
      exp0_q.push_back(rom0[i]);
      exp0_cyc_q.push_back(c0 + 4 + i * 3);
    end
    m0_done_at   = c0 + 1 + N * 3;
    m0_busy_from = c0 + 1;
    m0_busy_to   = m0_done_at;
    m0_blk_to    = m0_done_at;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    bit ew, ew0;
    if (in_rst) begin
      chk("rst_lb_write", hbus.lb_write, 1'b0);
      chk("rst_lb_addr_data", {hbus.lb_addr, hbus.lb_data}, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_host_ready", hbus.host_ready, 1'b0);
      chk("rst_tbl_addr", tbl_addr, 2'd0);
      chk("rst_state", dbg_state, 3'd0);
      chk("rst0_lb_write", hbus0.lb_write, 1'b0);
      chk("rst0_busy", s0_busy, 1'b0);
      chk("rst0_state", s0_dbg, 3'd0);
    end else begin
      ew = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
      chk("lb_write", hbus.lb_write, ew);
      if (ew) begin
        chk("lb_addr_data", {hbus.lb_addr, hbus.lb_data}, exp_q[0]);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
      chk("done", done, cyc == done_at);
      chk("busy", busy, cyc >= busy_from && cyc <= busy_to);
      chk("host_ready", hbus.host_ready, model_ready(cyc));

      ew0 = (exp0_cyc_q.size() > 0) && (exp0_cyc_q[0] == cyc);
      chk("g0_lb_write", hbus0.lb_write, ew0);
      if (ew0) begin
        chk("g0_lb_addr_data", {hbus0.lb_addr, hbus0.lb_data}, exp0_q[0]);
        void'(exp0_q.pop_front());
        void'(exp0_cyc_q.pop_front());
      end
      chk("g0_done", s0_done, cyc == m0_done_at);
      chk("g0_busy", s0_busy, cyc >= m0_busy_from && cyc <= m0_busy_to);
      chk("g0_host_ready", hbus0.host_ready, model0_ready(cyc));
    end
  end

  // ---------------- driver tasks ----------------
  // Called 1 time unit after a rising edge; drives one cycle and returns 1 unit after the next edge.
  task automatic drive(input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                       input logic st, output logic acc);
    bit rdy;
    hbus.host_write = hw;
    hbus.host_addr  = ha;
    hbus.host_data  = hd;
    start           = st;
    rdy = model_ready(cyc);
    acc = hw && rdy;
    if (acc) begin
      exp_q.push_back({ha, hd});
      exp_cyc_q.push_back(cyc + 1);
    end
    if (st && rdy) begin
      blk_from = cyc + 1;
      schedule(acc ? cyc + 1 : cyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    rst_n       = 1'b1;
    in_rst      = 1'b0;
    blk_from    = cyc;
    schedule(cyc);
    m0_blk_from = cyc;
    schedule0(cyc);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    in_rst = 1'b1;
    hbus.host_write = 1'b0;
    start = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    exp0_q.delete();
    exp0_cyc_q.delete();
    done_at = -1; busy_from = 1; busy_to = 0; blk_from = 1; blk_to = 0;
    m0_done_at = -1; m0_busy_from = 1; m0_busy_to = 0; m0_blk_from = 1; m0_blk_to = 0;
    #1;
    chk("async_lb_write", hbus.lb_write, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_host_ready", hbus.host_ready, 1'b0);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    release_rst();
  endtask

  task automatic wait_idle();
    logic acc;
    for (int k = 0; k < 80; k++) begin
      if (model_ready(cyc)) break;
      drive(1'b0, '0, '0, 1'b0, acc);
    end
    chk("idle_ready", hbus.host_ready, 1'b1);
  endtask

  task automatic hold_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 40 && !acc; k++) drive(1'b1, a, d, 1'b0, acc);
    chk("hold_accept", acc, 1'b1);
  endtask

  task automatic fill_rom(input int term_idx);
    for (int i = 0; i < N; i++) begin
      rom[i] = {AW'($urandom_range(0, 32'h7FFE)), DW'($urandom())};
      if (i == term_idx) rom[i][TW-1:DW] = {AW{1'b1}};
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    int   c0;
    bit   st, hw;
    hbus.host_write  = 1'b0;
    hbus.host_addr   = '0;
    hbus.host_data   = '0;
    hbus0.host_write = 1'b0;
    hbus0.host_addr  = '0;
    hbus0.host_data  = '0;
    rom[0] = {15'h100, 32'd57000};
    rom[1] = {15'h101, 32'd0};
    rom[2] = {15'h102, 32'd0};
    rom[3] = {15'h103, 32'd0};
    for (int i = 0; i < N; i++) rom0[i] = {AW'(32'h200 + i), DW'(32'hA5A50000 + i)};

    // Auto replay after reset release.
    repeat (3) @(posedge clk);
    #1;
    release_rst();
    wait_idle();

    // Back-to-back host writes in IDLE.
    for (int i = 0; i < 4; i++) drive(1'b1, AW'(32'h10 + i), DW'($urandom()), 1'b0, acc);

    // Host write held through a replay.
    wait_idle();
    drive(1'b0, '0, '0, 1'b1, acc);
    hold_write(15'h0055, DW'($urandom()));
    drive(1'b0, '0, '0, 1'b0, acc);

    // Terminator at entry 2, plus a start while busy.
    wait_idle();
    fill_rom(2);
    drive(1'b0, '0, '0, 1'b1, acc);
    drive(1'b0, '0, '0, 1'b0, acc);
    drive(1'b0, '0, '0, 1'b1, acc);
    wait_idle();

    // Reset during the WRITE of entry 1, then auto restart from entry 0.
    fill_rom(-1);
    c0 = cyc;
    drive(1'b0, '0, '0, 1'b1, acc);
    while (cyc < c0 + 3 + (3 + G)) drive(1'b0, '0, '0, 1'b0, acc);
    do_reset(2);
    wait_idle();

    // Same-cycle start and host write.
    drive(1'b1, 15'h00AA, DW'($urandom()), 1'b1, acc);
    wait_idle();

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      hw = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 24) == 0);
      if (model_ready(cyc) && !st && $urandom_range(0, 9) == 0)
        fill_rom(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1);
      drive(hw, AW'($urandom_range(0, 32'h7FFF)), DW'($urandom()), st, acc);
    end

    wait_idle();
    repeat (20) drive(1'b0, '0, '0, 1'b0, acc);
    chk("sb_drained", exp_q.size(), 0);
    chk("sb0_drained", exp0_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
